// File: rtl/instr_fetch_queue_pkg.sv
// Shared fetch-path constants and the FIFO entry layout, common with decode and the cpu top.
package instr_fetch_queue_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_W    = 32;
  localparam int unsigned ENTRY_W = PC_W + INSTR_W;

  localparam logic [PC_W-1:0] PC_STEP          = 32'd4;
  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Instructions are word aligned, so the low two target bits carry no meaning.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched {pc, instr} entries; head is read straight from storage registers.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     head_valid,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_s;
  logic             pop_s;

  // Accept pop only when occupied; a push into a full queue only when a pop frees a slot.
  always_comb begin
    pop_s      = pop && (count_r != {CNT_W{1'b0}});
    push_s     = push && ((count_r != CNT_MAX) || pop_s);
    head_valid = (count_r != {CNT_W{1'b0}});
    head_data  = mem_r[rd_ptr_r];
    count      = count_r;
  end

  // Pointer and occupancy bookkeeping; flush empties the queue and ignores that cycle's push/pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch control: issues sequential word reads under a credit limit, buffers returns, and redirects on taken jumps.
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int unsigned      DEPTH    = 4,
  parameter logic [PC_W-1:0]  RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_en,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  input  logic               instr_ready
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_OCC = (CNT_W + 1)'(DEPTH);

  logic [PC_W-1:0]  fetch_pc_r;
  logic [PC_W-1:0]  inflight_pc_r;
  logic             inflight_r;
  logic             drop_r;

  logic [CNT_W-1:0] count_s;
  logic [CNT_W:0]   occupancy_s;
  logic             head_valid_s;
  logic             pop_s;
  logic             push_s;
  logic             issue_s;
  fetch_entry_t     push_entry_s;
  fetch_entry_t     head_entry_s;

  // Credit check counts the outstanding read as occupied so the queue can never overflow.
  always_comb begin
    pop_s              = head_valid_s && instr_ready && !redirect_valid;
    push_s             = inflight_r && !drop_r && !redirect_valid;
    occupancy_s        = {1'b0, count_s} + {{CNT_W{1'b0}}, inflight_r} - {{CNT_W{1'b0}}, pop_s};
    issue_s            = rst_n && !redirect_valid && (occupancy_s < DEPTH_OCC);
    push_entry_s.pc    = inflight_pc_r;
    push_entry_s.instr = imem_rdata;
    imem_en            = issue_s;
    imem_addr          = fetch_pc_r;
    instr_valid        = head_valid_s;
    instr              = head_entry_s.instr;
    instr_pc           = head_entry_s.pc;
  end

  // Fetch PC, outstanding-read tracking and the post-redirect drop flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_r    <= RESET_PC;
      inflight_pc_r <= RESET_PC;
      inflight_r    <= 1'b0;
      drop_r        <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc_r    <= align_pc(redirect_pc);
      inflight_r    <= 1'b0;
      drop_r        <= inflight_r;
    end else begin
      drop_r <= 1'b0;
      if (issue_s) begin
        fetch_pc_r    <= fetch_pc_r + PC_STEP;
        inflight_pc_r <= fetch_pc_r;
        inflight_r    <= 1'b1;
      end else begin
        inflight_r    <= 1'b0;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fetch_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect_valid),
    .push       (push_s),
    .push_data  (push_entry_s),
    .pop        (pop_s),
    .head_valid (head_valid_s),
    .head_data  (head_entry_s),
    .count      (count_s)
  );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: cold start, backpressure, redirects, PC wrap and mid-stream reset.
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_en, w_imem_en;
  logic [31:0] imem_addr, w_imem_addr;
  logic [31:0] imem_rdata = 32'h0, w_imem_rdata = 32'h0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid, w_instr_valid;
  logic [31:0] instr, w_instr;
  logic [31:0] instr_pc, w_instr_pc;
  logic        instr_ready;
  logic        w_redirect_valid = 1'b0;
  logic [31:0] w_redirect_pc = 32'h0;
  logic        w_instr_ready = 1'b1;

  int check_cnt = 0;
  int err_cnt   = 0;
  int issue_cnt;

  always #5 clk = ~clk;

  instr_fetch_queue dut (
    .clk(clk), .rst_n(rst_n), .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .instr_valid(instr_valid),
    .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready)
  );

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .imem_en(w_imem_en), .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc), .instr_valid(w_instr_valid),
    .instr(w_instr), .instr_pc(w_instr_pc), .instr_ready(w_instr_ready)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0000_1000 + {2'b00, a[31:2]};
  endfunction

  // Synchronous instruction memories: data one cycle after the read request.
  always @(posedge clk) begin
    if (imem_en)   imem_rdata   <= mem_word(imem_addr);
    if (w_imem_en) w_imem_rdata <= mem_word(w_imem_addr);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_head(input string tag, input logic v, input logic [31:0] pc,
                             input logic [31:0] ins, input logic [31:0] exp_pc);
    check_eq({tag, " valid"}, {31'b0, v}, 32'd1);
    check_eq({tag, " pc"}, pc, exp_pc);
    check_eq({tag, " instr"}, ins, mem_word(exp_pc));
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst valid", {31'b0, instr_valid}, 32'd0);
    check_eq("rst imem_en", {31'b0, imem_en}, 32'd0);
    check_eq("rst addr", imem_addr, 32'h0);
    check_eq("rst wrap addr", w_imem_addr, 32'hFFFF_FFF8);

    // Cold start, consumer always ready; wrap instance runs in parallel
    instr_ready = 1'b1;
    @(negedge clk); rst_n = 1'b1; #1;
    check_eq("cold imem_en", {31'b0, imem_en}, 32'd1);
    check_eq("cold addr", imem_addr, 32'h0);
    @(negedge clk); #1;
    check_eq("cold valid c1", {31'b0, instr_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      expect_head("stream", instr_valid, instr_pc, instr, 32'(4 * i));
      expect_head("wrap", w_instr_valid, w_instr_pc, w_instr, 32'hFFFF_FFF8 + 32'(4 * i));
    end

    // Backpressure: ten cycles not ready, then drain
    do_reset();
    instr_ready = 1'b0; rst_n = 1'b1;
    issue_cnt = 0;
    #1;
    if (imem_en) issue_cnt++;
    for (int i = 1; i < 10; i++) begin
      @(negedge clk); #1;
      if (imem_en) issue_cnt++;
    end
    check_eq("bp issues", 32'(issue_cnt), 32'd4);
    check_eq("bp en full", {31'b0, imem_en}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); instr_ready = 1'b1; #1;
      expect_head("drain", instr_valid, instr_pc, instr, 32'(4 * i));
    end

    // Redirect with queue credit-full and one read outstanding
    do_reset();
    instr_ready = 1'b0; rst_n = 1'b1;
    repeat (4) @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0023; #1;
    check_eq("rd1 en", {31'b0, imem_en}, 32'd0);
    @(negedge clk); redirect_valid = 1'b0; #1;
    check_eq("rd1 valid n1", {31'b0, instr_valid}, 32'd0);
    check_eq("rd1 en n1", {31'b0, imem_en}, 32'd1);
    check_eq("rd1 addr n1", imem_addr, 32'h20);
    @(negedge clk); #1;
    check_eq("rd1 valid n2", {31'b0, instr_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); instr_ready = 1'b1; #1;
      expect_head("rd1 head", instr_valid, instr_pc, instr, 32'h20 + 32'(4 * i));
    end

    // Back-to-back redirects: last one wins
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h40; #1;
    check_eq("rd2 en a", {31'b0, imem_en}, 32'd0);
    @(negedge clk); redirect_pc = 32'h80; #1;
    check_eq("rd2 en b", {31'b0, imem_en}, 32'd0);
    @(negedge clk); redirect_valid = 1'b0; #1;
    check_eq("rd2 addr", imem_addr, 32'h80);
    check_eq("rd2 valid n1", {31'b0, instr_valid}, 32'd0);
    @(negedge clk); #1;
    check_eq("rd2 valid n2", {31'b0, instr_valid}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      expect_head("rd2 head", instr_valid, instr_pc, instr, 32'h80 + 32'(4 * i));
    end

    // One-cycle reset mid-stream
    @(negedge clk); rst_n = 1'b0; #1;
    check_eq("mrst en gated", {31'b0, imem_en}, 32'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    check_eq("mrst valid", {31'b0, instr_valid}, 32'd0);
    check_eq("mrst en", {31'b0, imem_en}, 32'd1);
    check_eq("mrst addr", imem_addr, 32'h0);
    @(negedge clk); #1;
    check_eq("mrst valid c1", {31'b0, instr_valid}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      expect_head("mrst head", instr_valid, instr_pc, instr, 32'(4 * i));
    end

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Fetch stage feeding the multi-core `cpu` issue logic. Generates sequential instruction addresses into a synchronous instruction memory, buffers returned words with their PCs in a small FIFO, and hands them downstream with a valid/ready handshake. A taken jump redirects fetch, flushes buffered and in-flight words, and restarts at the target.

## Interface
- `DEPTH`, 4: queue entries, power of two, ≥2.
- `RESET_PC`, 32'd0: first fetch address after reset.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `imem_en` out 1: read request this cycle.
- `imem_addr` out 32: byte address of request, word-aligned.
- `imem_rdata` in 32: read data, valid exactly one cycle after `imem_en`.
- `redirect_valid` in 1: taken jump/branch this cycle.
- `redirect_pc` in 32: target address; bits [1:0] ignored and treated as 0.
- `instr_valid` out 1: head entry available.
- `instr` out 32: head instruction word.
- `instr_pc` out 32: address of head instruction.
- `instr_ready` in 1: consumer accepts head this cycle.

## Operation
- State: `fetch_pc` (32), FIFO of {pc, instr}, `count` (0..DEPTH), `inflight` (1 bit), `inflight_pc` (32), `drop` (1 bit).
- Issue: `imem_en = rst_n && !redirect_valid && (count + inflight - pop < DEPTH)`, where pop = `instr_valid && instr_ready`. `imem_addr = fetch_pc`. On issue: `fetch_pc += 4` (mod 2^32, wraps 0xFFFFFFFC → 0), `inflight_pc <= fetch_pc`, `inflight <= 1`; otherwise `inflight <= 0`.
- Return: when `inflight && !drop`, push {`inflight_pc`, `imem_rdata`}. When `inflight && drop`, discard the word.
- Pop: on `instr_valid && instr_ready`, advance head. Push and pop in the same cycle are both honoured; count is unchanged.
- Redirect, highest priority: `fetch_pc <= {redirect_pc[31:2],2'b00}`, count and pointers are cleared, `drop <= inflight` (the response that returns next cycle is discarded), and no issue happens this cycle. Any pop or push in the redirect cycle is ignored. `instr_valid` stays at its pre-redirect value combinationally, but the consumer must not act on a handshake in the same cycle it asserts redirect.
- `drop` clears the cycle after it is set.
- Back-to-back redirects: the last one wins; each one restarts fetch.
- Credit rule guarantees no overflow. The FIFO never holds more than DEPTH entries, even with full throughput.
- Reset, asserted in any cycle including mid-fetch: the next state is `fetch_pc=RESET_PC`, count=0, inflight=0, drop=0. The pending memory response is ignored because inflight=0.

## Timing
- Reset values: `instr_valid=0`, `imem_en=0` (gated while `rst_n` low), `imem_addr=RESET_PC`. `instr` and `instr_pc` are don't-care while invalid, but driven from FIFO storage with no X-gating requirement.
- Cold start: in the first cycle after reset release, `imem_en=1` at RESET_PC. The word is pushed at the end of cycle +1 and `instr_valid=1` at cycle +2.
- Steady state, consumer always ready: one instruction per cycle, with consecutive PCs.
- Redirect in cycle N: issue to the target in N+1, target instruction valid in N+3. This gives a 2-cycle bubble.
- `instr_valid`, `instr`, and `instr_pc` come from registers only, with no combinational path from `imem_rdata` or `instr_ready`. `imem_en` depends combinationally on `instr_ready` and `redirect_valid`.

## Structure
- Shared cpu package/header holds `INSTR_W=32`, `PC_W=32`, `PC_STEP=4`, and `RESET_PC` default, so they are common with decode and the `cpu` top.
- One sub-module: `fetch_fifo`, a synchronous FIFO with parameters DEPTH and WIDTH=64. It has push, pop, flush, count, and a registered head. The fetch control (credit, inflight, drop, fetch_pc) lives in the top of `instr_fetch_queue`.

## Test plan
- Reset, then memory word i = 0x1000+i with `instr_ready=1` held → `instr_valid` rises 2 cycles after release. PCs 0,4,8,… pair with words 0x1000, 0x1001, …, one per cycle.
- `instr_ready=0` for 10 cycles → exactly DEPTH=4 entries buffered and `imem_en` low once full. After that, releasing ready drains PCs 0..12 in order with no loss or duplication.
- Redirect to 0x20 while the queue is full and one read is in flight → the in-flight word is dropped. The next valid output is `instr_pc=0x20` exactly 3 cycles later, and no stale PC appears.
- Redirect on two consecutive cycles (0x40 then 0x80) → only 0x80 and its successors emerge.
- `RESET_PC=32'hFFFFFFF8` → PCs FFFFFFF8, FFFFFFFC, 0, 4 with no stall at wrap.
- Assert `rst_n=0` mid-stream for one cycle → `instr_valid=0` the next cycle, then fetch restarts at RESET_PC. The word returning from the pre-reset request is never output.
